// File: rtl/dac_arb_pkg.sv
// Shared definitions for the DAC update arbiter: state encoding and the
// default widths that are also used by the DAC serial controller.
package dac_arb_pkg;

  // Default widths shared with the DAC controller
  localparam int DAC_W_DATA = 16;
  localparam int DAC_W_CHS  = 3;
  localparam int DAC_N_CHAN = 8;

  // Arbiter state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT
  } state_t;

endpackage

// File: rtl/dac_update_arbiter_rr_select.sv
// Combinational round-robin priority encoder. Searches the pending vector
// starting one past the last issued channel, wrapping at N_CHAN, and
// reports the first set bit.
module rr_select
  import dac_arb_pkg::*;
#(
  parameter int N_CHAN = DAC_N_CHAN,
  parameter int W_CHS  = DAC_W_CHS
) (
  input  logic [N_CHAN-1:0] pend,
  input  logic [W_CHS-1:0]  last_chan,
  output logic [W_CHS-1:0]  sel,
  output logic              any
);

  logic [W_CHS-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest set bit wins
  always_comb begin
    sel = '0;
    any = 1'b0;
    idx = '0;
    for (int k = N_CHAN; k >= 1; k--) begin
      idx = W_CHS'((int'(last_chan) + k) % N_CHAN);
      if (pend[idx]) begin
        sel = idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dac_update_arbiter.sv
// DAC update arbiter: keeps one pending value per channel (newest write
// wins), and hands them to the DAC controller one at a time in round-robin
// order, waiting for the controller's done pulse between issues.
// Optional feature macro: DAC_ARB_TIMEOUT_EN (bounded WAIT with re-queue).
module dac_update_arbiter
  import dac_arb_pkg::*;
#(
  parameter int W_DATA         = DAC_W_DATA,
  parameter int W_CHS          = DAC_W_CHS,
  parameter int N_CHAN         = DAC_N_CHAN,
  parameter int TIMEOUT_CYCLES = 63
) (
  input  logic              clk_in,
  input  logic              nreset_in,
  input  logic [W_DATA-1:0] wr_data_in,
  input  logic [W_CHS-1:0]  wr_chan_in,
  input  logic              wr_valid_in,
  output logic [W_DATA-1:0] dac_data_out,
  output logic [W_CHS-1:0]  dac_chan_out,
  output logic              dac_valid_out,
  input  logic              dac_done_in,
  output logic [N_CHAN-1:0] pending_out,
  output logic              busy_out,
  output logic              coalesce_out,
  output logic              timeout_out
);

  localparam logic [W_CHS:0]   CHAN_LIMIT = (W_CHS+1)'(N_CHAN);
  localparam logic [W_CHS-1:0] LAST_INIT  = W_CHS'(N_CHAN - 1);

  state_t            state, state_nxt;
  logic [W_DATA-1:0] val [N_CHAN];
  logic [N_CHAN-1:0] pend;
  logic [W_CHS-1:0]  last_chan;
  logic [W_CHS-1:0]  sel;
  logic              any;
  logic              do_sel;
  logic              wr_hit;
  logic              tmo_hit;

  // Writes to channels beyond N_CHAN are dropped
  assign wr_hit      = wr_valid_in && ({1'b0, wr_chan_in} < CHAN_LIMIT);
  assign pending_out = pend;
  assign busy_out    = (state != S_IDLE);

  rr_select #(
    .N_CHAN (N_CHAN),
    .W_CHS  (W_CHS)
  ) u_rr_select (
    .pend      (pend),
    .last_chan (last_chan),
    .sel       (sel),
    .any       (any)
  );

  // Next-state and issue strobe; IDLE selects whenever anything is pending
  always_comb begin
    state_nxt     = state;
    do_sel        = 1'b0;
    dac_valid_out = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (any) begin
          do_sel    = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        dac_valid_out = 1'b1;
        state_nxt     = S_WAIT;
      end
      S_WAIT: begin
        if (dac_done_in || tmo_hit) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_in or negedge nreset_in) begin
    if (!nreset_in) state <= S_IDLE;
    else            state <= state_nxt;
  end

  // Per-channel value store; the newest write always lands
  always_ff @(posedge clk_in or negedge nreset_in) begin
    if (!nreset_in) begin
      for (int i = 0; i < N_CHAN; i++) val[i] <= '0;
    end else if (wr_hit) begin
      for (int i = 0; i < N_CHAN; i++) begin
        if (wr_chan_in == W_CHS'(i)) val[i] <= wr_data_in;
      end
    end
  end

  // Pending flags: a write beats a same-cycle selection, so a value written
  // while its channel is being issued stays queued for the next round
  always_ff @(posedge clk_in or negedge nreset_in) begin
    if (!nreset_in) begin
      pend <= '0;
    end else begin
      for (int i = 0; i < N_CHAN; i++) begin
        if (wr_hit && (wr_chan_in == W_CHS'(i)))      pend[i] <= 1'b1;
        else if (do_sel && (sel == W_CHS'(i)))        pend[i] <= 1'b0;
        else if (tmo_hit && (dac_chan_out == W_CHS'(i))) pend[i] <= 1'b1;
      end
    end
  end

  // Latch the selected channel and its pre-write value; held until next selection
  always_ff @(posedge clk_in or negedge nreset_in) begin
    if (!nreset_in) begin
      dac_data_out <= '0;
      dac_chan_out <= '0;
      last_chan    <= LAST_INIT;
    end else if (do_sel) begin
      dac_data_out <= val[sel];
      dac_chan_out <= sel;
      last_chan    <= sel;
    end
  end

  // Flag a write that lands on a channel already holding an unsent value
  always_ff @(posedge clk_in or negedge nreset_in) begin
    if (!nreset_in) coalesce_out <= 1'b0;
    else            coalesce_out <= wr_hit && pend[wr_chan_in];
  end

`ifdef DAC_ARB_TIMEOUT_EN
  localparam int               W_CNT    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W_CNT-1:0] CNT_TERM = W_CNT'(TIMEOUT_CYCLES);

  logic [W_CNT-1:0] wait_cnt;

  // Counts WAIT cycles including the current one; loaded on the way in
  always_ff @(posedge clk_in or negedge nreset_in) begin
    if (!nreset_in)             wait_cnt <= '0;
    else if (state == S_ISSUE)  wait_cnt <= W_CNT'(1);
    else if (state == S_WAIT)   wait_cnt <= wait_cnt + 1'b1;
  end

  // A done on the terminal cycle is a success, not an abort
  assign tmo_hit = (state == S_WAIT) && !dac_done_in && (wait_cnt == CNT_TERM);

  // One-cycle abort indication, coincident with the return to IDLE
  always_ff @(posedge clk_in or negedge nreset_in) begin
    if (!nreset_in) timeout_out <= 1'b0;
    else            timeout_out <= tmo_hit;
  end
`else
  // Keeps the parameter referenced in builds without the WAIT counter
  localparam int tmo_unused = TIMEOUT_CYCLES;

  assign tmo_hit     = 1'b0;
  assign timeout_out = 1'b0;
`endif

endmodule

// File: tb/tb_dac_update_arbiter.sv
// Directed bench for dac_update_arbiter. Inputs are driven and outputs
// sampled on the falling clock edge.
module tb_dac_update_arbiter;
  import dac_arb_pkg::*;

  localparam int W_DATA         = 16;
  localparam int W_CHS          = 3;
  localparam int N_CHAN         = 8;
  localparam int TIMEOUT_CYCLES = 63;

  logic              clk = 1'b0;
  logic              nreset = 1'b0;
  logic [W_DATA-1:0] wr_data = '0;
  logic [W_CHS-1:0]  wr_chan = '0;
  logic              wr_valid = 1'b0;
  logic [W_DATA-1:0] dac_data;
  logic [W_CHS-1:0]  dac_chan;
  logic              dac_valid;
  logic              dac_done = 1'b0;
  logic [N_CHAN-1:0] pending;
  logic              busy;
  logic              coalesce;
  logic              timeout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dac_update_arbiter #(
    .W_DATA         (W_DATA),
    .W_CHS          (W_CHS),
    .N_CHAN         (N_CHAN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk_in        (clk),
    .nreset_in     (nreset),
    .wr_data_in    (wr_data),
    .wr_chan_in    (wr_chan),
    .wr_valid_in   (wr_valid),
    .dac_data_out  (dac_data),
    .dac_chan_out  (dac_chan),
    .dac_valid_out (dac_valid),
    .dac_done_in   (dac_done),
    .pending_out   (pending),
    .busy_out      (busy),
    .coalesce_out  (coalesce),
    .timeout_out   (timeout)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_write(input logic [W_CHS-1:0] ch, input logic [W_DATA-1:0] d);
    wr_chan  = ch;
    wr_data  = d;
    wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic pulse_done;
    dac_done = 1'b1;
    @(negedge clk);
    dac_done = 1'b0;
  endtask

  task automatic test_reset;
    nreset = 1'b0;
    step(2);
    n_cmp++; if ({dac_data, dac_chan, dac_valid, pending, busy, coalesce, timeout} !== 31'd0) begin n_bad++; $display("FAIL reset_outputs: got data=%h chan=%0d vld=%b pend=%b busy=%b coal=%b tmo=%b, want all 0", dac_data, dac_chan, dac_valid, pending, busy, coalesce, timeout); end
    nreset = 1'b1;
    step(2);
    n_cmp++; if ({busy, dac_valid, pending} !== 10'd0) begin n_bad++; $display("FAIL reset_release_idle: got busy=%b vld=%b pend=%b, want 0 0 0", busy, dac_valid, pending); end
  endtask

  task automatic test_single;
    drive_write(3'd3, 16'h1234);
    n_cmp++; if ({dac_valid, pending} !== {1'b0, 8'h08}) begin n_bad++; $display("FAIL single_pend: got vld=%b pend=%b, want 0 00001000", dac_valid, pending); end
    step(1);
    n_cmp++; if ({dac_valid, dac_chan, dac_data} !== {1'b1, 3'd3, 16'h1234}) begin n_bad++; $display("FAIL single_issue: got vld=%b chan=%0d data=%h, want 1 3 1234", dac_valid, dac_chan, dac_data); end
    n_cmp++; if ({pending, busy} !== {8'h00, 1'b1}) begin n_bad++; $display("FAIL single_pend_clear: got pend=%b busy=%b, want 0 1", pending, busy); end
    step(1);
    n_cmp++; if ({dac_valid, busy, dac_chan, dac_data} !== {1'b0, 1'b1, 3'd3, 16'h1234}) begin n_bad++; $display("FAIL single_wait_hold: got vld=%b busy=%b chan=%0d data=%h, want 0 1 3 1234", dac_valid, busy, dac_chan, dac_data); end
    pulse_done;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_done_idle: got busy=%b, want 0", busy); end
  endtask

  task automatic test_back_to_back;
    logic [W_CHS-1:0]  exp_ch [3];
    logic [W_DATA-1:0] exp_d  [3];
    exp_ch[0] = 3'd1; exp_d[0] = 16'h0002;
    exp_ch[1] = 3'd5; exp_d[1] = 16'h0001;
    exp_ch[2] = 3'd6; exp_d[2] = 16'h0003;
    drive_write(3'd0, 16'h00A0);
    step(1);
    n_cmp++; if ({dac_valid, dac_chan, dac_data} !== {1'b1, 3'd0, 16'h00A0}) begin n_bad++; $display("FAIL b2b_issue0: got vld=%b chan=%0d data=%h, want 1 0 00a0", dac_valid, dac_chan, dac_data); end
    drive_write(3'd5, 16'h0001);
    drive_write(3'd1, 16'h0002);
    drive_write(3'd6, 16'h0003);
    n_cmp++; if ({busy, pending} !== {1'b1, 8'h62}) begin n_bad++; $display("FAIL b2b_pending: got busy=%b pend=%b, want 1 01100010", busy, pending); end
    for (int i = 0; i < 3; i++) begin
      pulse_done;
      step(1);
      n_cmp++; if ({dac_valid, dac_chan, dac_data} !== {1'b1, exp_ch[i], exp_d[i]}) begin n_bad++; $display("FAIL b2b_issue%0d: got vld=%b chan=%0d data=%h, want 1 %0d %h", i + 1, dac_valid, dac_chan, dac_data, exp_ch[i], exp_d[i]); end
      // a done pulse during ISSUE must not end the transaction
      pulse_done;
      n_cmp++; if ({busy, dac_valid} !== 2'b10) begin n_bad++; $display("FAIL b2b_done_in_issue%0d: got busy=%b vld=%b, want 1 0", i + 1, busy, dac_valid); end
    end
    pulse_done;
    n_cmp++; if ({busy, pending} !== 9'd0) begin n_bad++; $display("FAIL b2b_drained: got busy=%b pend=%b, want 0 0", busy, pending); end
  endtask

  task automatic test_coalesce;
    drive_write(3'd7, 16'h0777);
    step(1);
    n_cmp++; if ({dac_valid, dac_chan, dac_data} !== {1'b1, 3'd7, 16'h0777}) begin n_bad++; $display("FAIL coal_issue7: got vld=%b chan=%0d data=%h, want 1 7 0777", dac_valid, dac_chan, dac_data); end
    drive_write(3'd2, 16'hAAAA);
    n_cmp++; if (coalesce !== 1'b0) begin n_bad++; $display("FAIL coal_first_write: got coalesce=%b, want 0", coalesce); end
    drive_write(3'd2, 16'h5555);
    n_cmp++; if ({coalesce, pending} !== {1'b1, 8'h04}) begin n_bad++; $display("FAIL coal_second_write: got coalesce=%b pend=%b, want 1 00000100", coalesce, pending); end
    step(1);
    n_cmp++; if (coalesce !== 1'b0) begin n_bad++; $display("FAIL coal_pulse_width: got coalesce=%b, want 0", coalesce); end
    pulse_done;
    step(1);
    n_cmp++; if ({dac_valid, dac_chan, dac_data} !== {1'b1, 3'd2, 16'h5555}) begin n_bad++; $display("FAIL coal_issue2: got vld=%b chan=%0d data=%h, want 1 2 5555", dac_valid, dac_chan, dac_data); end
    step(1);
    pulse_done;
    step(2);
    n_cmp++; if ({busy, pending} !== 9'd0) begin n_bad++; $display("FAIL coal_single_issue: got busy=%b pend=%b, want 0 0", busy, pending); end
  endtask

  task automatic test_write_wins;
    drive_write(3'd3, 16'h0333);
    step(1);
    drive_write(3'd4, 16'h1111);
    pulse_done;
    // this write lands on the same edge that selects channel 4
    drive_write(3'd4, 16'hBEEF);
    n_cmp++; if ({dac_valid, dac_chan, dac_data} !== {1'b1, 3'd4, 16'h1111}) begin n_bad++; $display("FAIL wins_old_issued: got vld=%b chan=%0d data=%h, want 1 4 1111", dac_valid, dac_chan, dac_data); end
    n_cmp++; if (pending !== 8'h10) begin n_bad++; $display("FAIL wins_pend_kept: got pend=%b, want 00010000", pending); end
    step(1);
    pulse_done;
    step(1);
    n_cmp++; if ({dac_valid, dac_chan, dac_data} !== {1'b1, 3'd4, 16'hBEEF}) begin n_bad++; $display("FAIL wins_new_issued: got vld=%b chan=%0d data=%h, want 1 4 beef", dac_valid, dac_chan, dac_data); end
    n_cmp++; if (pending !== 8'h00) begin n_bad++; $display("FAIL wins_drained: got pend=%b, want 0", pending); end
    step(1);
    pulse_done;
  endtask

  task automatic test_timeout;
    logic seen_tmo;
    seen_tmo = 1'b0;
    drive_write(3'd7, 16'h7777);
    step(1);
    n_cmp++; if ({dac_valid, dac_chan, dac_data} !== {1'b1, 3'd7, 16'h7777}) begin n_bad++; $display("FAIL tmo_issue7: got vld=%b chan=%0d data=%h, want 1 7 7777", dac_valid, dac_chan, dac_data); end
`ifdef DAC_ARB_TIMEOUT_EN
    step(TIMEOUT_CYCLES);
    n_cmp++; if ({busy, timeout} !== 2'b10) begin n_bad++; $display("FAIL tmo_last_wait: got busy=%b tmo=%b, want 1 0", busy, timeout); end
    step(1);
    n_cmp++; if ({timeout, busy, pending} !== {1'b1, 1'b0, 8'h80}) begin n_bad++; $display("FAIL tmo_abort: got tmo=%b busy=%b pend=%b, want 1 0 10000000", timeout, busy, pending); end
    step(1);
    n_cmp++; if ({dac_valid, dac_chan, dac_data, timeout} !== {1'b1, 3'd7, 16'h7777, 1'b0}) begin n_bad++; $display("FAIL tmo_reissue: got vld=%b chan=%0d data=%h tmo=%b, want 1 7 7777 0", dac_valid, dac_chan, dac_data, timeout); end
    step(1);
    pulse_done;
`else
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (timeout !== 1'b0) seen_tmo = 1'b1;
    end
    n_cmp++; if ({busy, seen_tmo} !== 2'b10) begin n_bad++; $display("FAIL notmo_stays_busy: got busy=%b tmo_seen=%b, want 1 0", busy, seen_tmo); end
    pulse_done;
`endif
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL tmo_final_idle: got busy=%b, want 0", busy); end
  endtask

  task automatic test_reset_mid_wait;
    logic seen_vld;
    seen_vld = 1'b0;
    drive_write(3'd0, 16'h0100);
    step(1);
    drive_write(3'd1, 16'h0101);
    drive_write(3'd2, 16'h0102);
    drive_write(3'd3, 16'h0103);
    n_cmp++; if ({busy, pending} !== {1'b1, 8'h0E}) begin n_bad++; $display("FAIL rst_pre_pending: got busy=%b pend=%b, want 1 00001110", busy, pending); end
    #2 nreset = 1'b0;
    #1;
    n_cmp++; if ({dac_data, dac_chan, dac_valid, pending, busy, coalesce, timeout} !== 31'd0) begin n_bad++; $display("FAIL rst_async_clear: got data=%h chan=%0d vld=%b pend=%b busy=%b coal=%b tmo=%b, want all 0", dac_data, dac_chan, dac_valid, pending, busy, coalesce, timeout); end
    @(negedge clk);
    nreset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (dac_valid !== 1'b0 || busy !== 1'b0) seen_vld = 1'b1;
    end
    n_cmp++; if ({seen_vld, pending} !== 9'd0) begin n_bad++; $display("FAIL rst_no_issue: got activity=%b pend=%b, want 0 0", seen_vld, pending); end
    drive_write(3'd5, 16'h0555);
    step(1);
    n_cmp++; if ({dac_valid, dac_chan, dac_data} !== {1'b1, 3'd5, 16'h0555}) begin n_bad++; $display("FAIL rst_new_issue: got vld=%b chan=%0d data=%h, want 1 5 0555", dac_valid, dac_chan, dac_data); end
    step(1);
    pulse_done;
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_coalesce;
    test_write_wins;
    test_timeout;
    test_reset_mid_wait;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
